sch_data_align: RTL and testbench

SCH_DATA_ALIGN -- requirements
Module: sch_data_align

---
 rtl/sch_pkg.sv | 13 +
 rtl/sch_data_align_if.sv | 31 +++
 rtl/sch_skid_fifo.sv | 52 +++++
 rtl/sch_data_align.sv | 168 ++++++++++++++++
 tb/tb_sch_data_align.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sch_pkg.sv
// Shared widths and constants for the scheduler data-align path.
// Holds PE array geometry, FIFO depth and buffer read latency.
package sch_pkg;
    localparam int IFM_W      = 8;
    localparam int SCH_COLS   = 40;
    localparam int PE_COLS    = 32;
    localparam int PE_ROWS    = 4;
    localparam int PE_ICS     = 4;
    localparam int PE_OCS     = 4;
    localparam int WT_W       = 16;
    localparam int FIFO_DEPTH = 3;
    localparam int RD_LAT     = 1;
endpackage

// File: rtl/sch_data_align_if.sv
// PE-side valid/ready bus: ifm/wt payload plus col/row masks and row_last.
// master drives payload and pe_vld; slave returns pe_rdy.
interface sch_data_align_if
    import sch_pkg::*;
#(
    parameter int ROWS = PE_ROWS,
    parameter int COLS = PE_COLS,
    parameter int IW   = IFM_W,
    parameter int ICS  = PE_ICS,
    parameter int OCS  = PE_OCS,
    parameter int WW   = WT_W
) ();
    logic                     pe_vld;
    logic                     pe_rdy;
    logic [ROWS*COLS*IW-1:0]  pe_ifm;
    logic [ICS*OCS*WW-1:0]    pe_wt;
    logic [COLS-1:0]          pe_col_vld;
    logic [ROWS-1:0]          pe_row_vld;
    logic                     pe_row_last;

    modport master (
        output pe_vld, pe_ifm, pe_wt,
        output pe_col_vld, pe_row_vld, pe_row_last,
        input  pe_rdy
    );
    modport slave (
        input  pe_vld, pe_ifm, pe_wt,
        input  pe_col_vld, pe_row_vld, pe_row_last,
        output pe_rdy
    );
endinterface

// File: rtl/sch_skid_fifo.sv
// Small FIFO of WIDTH x DEPTH (any depth); push/pop may share a cycle.
// Ports: clk, rst, push/push_data, pop/pop_data, empty, full, cnt.
module sch_skid_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    cnt
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // a push into a full FIFO only lands if a pop frees a slot
    assign do_push = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop)  rd_ptr <= inc(rd_ptr);
            if (do_push && !do_pop)      cnt <= cnt + 1'b1;
            else if (!do_push && do_pop) cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/sch_data_align.sv
// Aligns fe/olp buffer rows into PE ifm columns and queues beats to the PE.
// Ports: clk/rst, sch2pe sideband + buffer read data in, align_rdy,
// align_ovf_err out, PE bus via sch_data_align_if.master.
// Option: SCH_ALIGN_ZERO_MASK_EN zeroes masked cols/rows/IC groups.
module sch_data_align
    import sch_pkg::*;
#(
    parameter int IFM_WIDTH   = IFM_W,
    parameter int SCH_COL_NUM = SCH_COLS,
    parameter int PE_COL_NUM  = PE_COLS,
    parameter int PE_ROW_NUM  = PE_ROWS,
    parameter int PE_IC_NUM   = PE_ICS,
    parameter int PE_OC_NUM   = PE_OCS,
    parameter int WT_WIDTH    = WT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic sch2pe_vld,
    input  logic [PE_ROW_NUM-1:0] fe_olp_buf_rd_en,
    input  logic [2:0] addr_offset_r,
    input  logic [PE_COL_NUM-1:0] mux_col_vld,
    input  logic [PE_ROW_NUM-1:0] mux_row_vld,
    input  logic [PE_IC_NUM-1:0] mux_array_vld,
    input  logic row_done,
    input  logic [SCH_COL_NUM*IFM_WIDTH-1:0] fe_buf_rd_data_0,
    input  logic [SCH_COL_NUM*IFM_WIDTH-1:0] fe_buf_rd_data_1,
    input  logic [SCH_COL_NUM*IFM_WIDTH-1:0] fe_buf_rd_data_2,
    input  logic [SCH_COL_NUM*IFM_WIDTH-1:0] fe_buf_rd_data_3,
    input  logic [(SCH_COL_NUM-PE_COL_NUM)*IFM_WIDTH-1:0] olp_buf_rd_data_0,
    input  logic [(SCH_COL_NUM-PE_COL_NUM)*IFM_WIDTH-1:0] olp_buf_rd_data_1,
    input  logic [(SCH_COL_NUM-PE_COL_NUM)*IFM_WIDTH-1:0] olp_buf_rd_data_2,
    input  logic [(SCH_COL_NUM-PE_COL_NUM)*IFM_WIDTH-1:0] olp_buf_rd_data_3,
    input  logic [PE_IC_NUM*PE_OC_NUM*WT_WIDTH-1:0] wt_buf_rd_data,
    output logic align_rdy,
    output logic align_ovf_err,
    sch_data_align_if.master pe
);
    localparam int FE_W    = SCH_COL_NUM * IFM_WIDTH;
    localparam int OLP_W   = (SCH_COL_NUM - PE_COL_NUM) * IFM_WIDTH;
    localparam int ROW_W   = PE_COL_NUM * IFM_WIDTH;
    localparam int IFM_TOT = PE_ROW_NUM * ROW_W;
    localparam int GRP_W   = PE_OC_NUM * WT_WIDTH;
    localparam int WT_TOT  = PE_IC_NUM * GRP_W;
    localparam int ENTRY_W = IFM_TOT + WT_TOT + PE_COL_NUM + PE_ROW_NUM + 1;
    localparam int CW      = $clog2(FIFO_DEPTH + 1);

    logic                  s1_vld;
    logic [PE_ROW_NUM-1:0] s1_olp;
    logic [2:0]            s1_off;
    logic [PE_COL_NUM-1:0] s1_col;
    logic [PE_ROW_NUM-1:0] s1_row;
    logic                  s1_last;
    logic [CW-1:0]         fifo_cnt;
    logic [CW:0]           occ;
    logic                  accept;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  pop;
    logic [FE_W-1:0]       fe_row  [PE_ROW_NUM];
    logic [OLP_W-1:0]      olp_row [PE_ROW_NUM];
    logic [FE_W-1:0]       comp;
    logic [FE_W-1:0]       shifted;
    logic [IFM_TOT-1:0]    ifm_s1;
    logic [WT_TOT-1:0]     wt_s1;
    logic [ENTRY_W-1:0]    head;

    assign fe_row[0]  = fe_buf_rd_data_0;
    assign fe_row[1]  = fe_buf_rd_data_1;
    assign fe_row[2]  = fe_buf_rd_data_2;
    assign fe_row[3]  = fe_buf_rd_data_3;
    assign olp_row[0] = olp_buf_rd_data_0;
    assign olp_row[1] = olp_buf_rd_data_1;
    assign olp_row[2] = olp_buf_rd_data_2;
    assign olp_row[3] = olp_buf_rd_data_3;

    // credit counts the beat still in S1 so a full FIFO never overflows
    assign occ       = {1'b0, fifo_cnt} + (CW+1)'(s1_vld);
    assign align_rdy = (occ <= (CW+1)'(FIFO_DEPTH - 1));
    assign accept    = sch2pe_vld && align_rdy;
    assign pop       = pe.pe_vld && pe.pe_rdy;

`ifdef SCH_ALIGN_ZERO_MASK_EN
    logic [PE_IC_NUM-1:0] s1_arr;
`else
    logic unused_arr;
    assign unused_arr = ^mux_array_vld;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_olp  <= '0;
            s1_off  <= '0;
            s1_col  <= '0;
            s1_row  <= '0;
            s1_last <= 1'b0;
`ifdef SCH_ALIGN_ZERO_MASK_EN
            s1_arr  <= '0;
`endif
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_olp  <= fe_olp_buf_rd_en;
                s1_off  <= addr_offset_r;
                s1_col  <= mux_col_vld;
                s1_row  <= mux_row_vld;
                s1_last <= row_done;
`ifdef SCH_ALIGN_ZERO_MASK_EN
                s1_arr  <= mux_array_vld;
`endif
            end
        end
    end

    // buffer data is live in S1; olp bytes sit below fe cols when selected
    always_comb begin
        comp    = '0;
        shifted = '0;
        ifm_s1  = '0;
        wt_s1   = wt_buf_rd_data;
        for (int r = 0; r < PE_ROW_NUM; r++) begin
            comp = s1_olp[r] ? {fe_row[r][ROW_W-1:0], olp_row[r]}
                             : fe_row[r];
            shifted = comp >> (int'(s1_off) * IFM_WIDTH);
            ifm_s1[r*ROW_W +: ROW_W] = shifted[ROW_W-1:0];
        end
`ifdef SCH_ALIGN_ZERO_MASK_EN
        for (int r = 0; r < PE_ROW_NUM; r++) begin
            for (int j = 0; j < PE_COL_NUM; j++) begin
                if (!s1_row[r] || !s1_col[j])
                    ifm_s1[(r*PE_COL_NUM+j)*IFM_WIDTH +: IFM_WIDTH] = '0;
            end
        end
        for (int i = 0; i < PE_IC_NUM; i++) begin
            if (!s1_arr[i]) wt_s1[i*GRP_W +: GRP_W] = '0;
        end
`endif
    end

    sch_skid_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s1_vld),
        .push_data ({ifm_s1, wt_s1, s1_col, s1_row, s1_last}),
        .pop       (pop),
        .pop_data  (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .cnt       (fifo_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst)
            align_ovf_err <= 1'b0;
        else if (s1_vld && fifo_full && !pop)
            align_ovf_err <= 1'b1;
    end

    assign pe.pe_vld      = !fifo_empty;
    assign pe.pe_ifm      = rst ? '0 : head[ENTRY_W-1 -: IFM_TOT];
    assign pe.pe_wt       = rst ? '0 : head[PE_COL_NUM+PE_ROW_NUM+1 +: WT_TOT];
    assign pe.pe_col_vld  = rst ? '0 : head[PE_ROW_NUM+1 +: PE_COL_NUM];
    assign pe.pe_row_vld  = rst ? '0 : head[1 +: PE_ROW_NUM];
    assign pe.pe_row_last = rst ? 1'b0 : head[0];
endmodule

// File: tb/tb_sch_data_align.sv
// Scoreboard bench for sch_data_align: directed beats, queued expectations.
// Honours SCH_ALIGN_ZERO_MASK_EN in its reference model.
module tb_sch_data_align;
    import sch_pkg::*;

    typedef struct packed {
        logic [3:0]   olp;
        logic [2:0]   off;
        logic [31:0]  col;
        logic [3:0]   row;
        logic [3:0]   arr;
        logic         last;
        logic [7:0]   base;
        logic [7:0]   rstep;
        logic [7:0]   obase;
        logic [255:0] wt;
    } beat_t;

    typedef struct packed {
        logic [1023:0] ifm;
        logic [255:0]  wt;
        logic [31:0]   col;
        logic [3:0]    row;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic sch2pe_vld;
    logic [3:0] fe_olp_buf_rd_en;
    logic [2:0] addr_offset_r;
    logic [31:0] mux_col_vld;
    logic [3:0] mux_row_vld;
    logic [3:0] mux_array_vld;
    logic row_done;
    logic [319:0] fe0, fe1, fe2, fe3;
    logic [63:0] olp0, olp1, olp2, olp3;
    logic [255:0] wt_buf_rd_data;
    logic align_rdy;
    logic align_ovf_err;

    sch_data_align_if pe_bus ();

    sch_data_align dut (
        .clk               (clk),
        .rst               (rst),
        .sch2pe_vld        (sch2pe_vld),
        .fe_olp_buf_rd_en  (fe_olp_buf_rd_en),
        .addr_offset_r     (addr_offset_r),
        .mux_col_vld       (mux_col_vld),
        .mux_row_vld       (mux_row_vld),
        .mux_array_vld     (mux_array_vld),
        .row_done          (row_done),
        .fe_buf_rd_data_0  (fe0),
        .fe_buf_rd_data_1  (fe1),
        .fe_buf_rd_data_2  (fe2),
        .fe_buf_rd_data_3  (fe3),
        .olp_buf_rd_data_0 (olp0),
        .olp_buf_rd_data_1 (olp1),
        .olp_buf_rd_data_2 (olp2),
        .olp_buf_rd_data_3 (olp3),
        .wt_buf_rd_data    (wt_buf_rd_data),
        .align_rdy         (align_rdy),
        .align_ovf_err     (align_ovf_err),
        .pe                (pe_bus)
    );

    always #5 clk = ~clk;

    exp_t  q[$];
    exp_t  mon_e;
    beat_t pend;
    beat_t idle;
    int    errors = 0;
    int    checks = 0;

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] fe_byte(beat_t b, int r, int c);
        return 8'(int'(b.base) + c + r * int'(b.rstep));
    endfunction

    function automatic logic [7:0] olp_byte(beat_t b, int k);
        return 8'(int'(b.obase) + k);
    endfunction

    function automatic logic [255:0] wt_pat(int seed);
        logic [255:0] w;
        for (int i = 0; i < 16; i++) w[i*16 +: 16] = 16'(seed * 256 + i);
        return w;
    endfunction

    function automatic beat_t mk(logic [3:0] olp, logic [2:0] off,
                                 logic [31:0] col, logic [3:0] row,
                                 logic [3:0] arr, logic last,
                                 logic [7:0] base, logic [7:0] rstep,
                                 logic [7:0] obase, int seed);
        beat_t b;
        b.olp = olp; b.off = off; b.col = col; b.row = row;
        b.arr = arr; b.last = last; b.base = base; b.rstep = rstep;
        b.obase = obase; b.wt = wt_pat(seed);
        return b;
    endfunction

    function automatic exp_t model(beat_t b);
        exp_t e;
        logic [7:0] v;
        int idx;
        e = '0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 32; j++) begin
                idx = j + int'(b.off);
                if (b.olp[r])
                    v = (idx < 8) ? olp_byte(b, idx) : fe_byte(b, r, idx - 8);
                else
                    v = fe_byte(b, r, idx);
`ifdef SCH_ALIGN_ZERO_MASK_EN
                if (!b.row[r] || !b.col[j]) v = 8'h00;
`endif
                e.ifm[(r*32+j)*8 +: 8] = v;
            end
        end
        e.wt = b.wt;
`ifdef SCH_ALIGN_ZERO_MASK_EN
        for (int i = 0; i < 4; i++)
            if (!b.arr[i]) e.wt[i*64 +: 64] = '0;
`endif
        e.col = b.col;
        e.row = b.row;
        e.last = b.last;
        return e;
    endfunction

    task automatic drive_data(input beat_t b);
        for (int c = 0; c < 40; c++) begin
            fe0[c*8 +: 8] = fe_byte(b, 0, c);
            fe1[c*8 +: 8] = fe_byte(b, 1, c);
            fe2[c*8 +: 8] = fe_byte(b, 2, c);
            fe3[c*8 +: 8] = fe_byte(b, 3, c);
        end
        for (int k = 0; k < 8; k++) begin
            olp0[k*8 +: 8] = olp_byte(b, k);
            olp1[k*8 +: 8] = olp_byte(b, k);
            olp2[k*8 +: 8] = olp_byte(b, k);
            olp3[k*8 +: 8] = olp_byte(b, k);
        end
        wt_buf_rd_data = b.wt;
    endtask

    // sideband of this beat and read data of the previous one
    task automatic step(input logic v, input beat_t b);
        @(posedge clk);
        #1;
        sch2pe_vld       = v;
        fe_olp_buf_rd_en = b.olp;
        addr_offset_r    = b.off;
        mux_col_vld      = b.col;
        mux_row_vld      = b.row;
        mux_array_vld    = b.arr;
        row_done         = b.last;
        drive_data(pend);
        pend = b;
    endtask

    task automatic send(input beat_t b);
        step(1'b1, b);
        q.push_back(model(b));
    endtask

    task automatic drain();
        int n;
        n = 0;
        pe_bus.pe_rdy = 1'b1;
        while ((q.size() != 0 || pe_bus.pe_vld) && n < 30) begin
            step(1'b0, idle);
            n++;
        end
        checks++;
        if (q.size() != 0 || pe_bus.pe_vld) begin
            errors++;
            $display("FAIL drain_timeout: left %0d want 0", q.size());
        end
    endtask

    function automatic logic [7:0] pix(int r, int j);
        return pe_bus.pe_ifm[(r*32+j)*8 +: 8];
    endfunction

    always @(negedge clk) begin
        if (!rst && pe_bus.pe_vld && pe_bus.pe_rdy) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got pe_vld=1 want none");
            end else begin
                mon_e = q.pop_front();
                for (int r = 0; r < 4; r++)
                    check($sformatf("sb_ifm_row%0d", r),
                          pe_bus.pe_ifm[r*256 +: 256], mon_e.ifm[r*256 +: 256]);
                check("sb_wt", pe_bus.pe_wt, mon_e.wt);
                check("sb_col", 256'(pe_bus.pe_col_vld), 256'(mon_e.col));
                check("sb_row", 256'(pe_bus.pe_row_vld), 256'(mon_e.row));
                check("sb_last", 256'(pe_bus.pe_row_last), 256'(mon_e.last));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1);
    end

    initial begin
        beat_t b;
        idle = mk(4'h0, 3'd0, 32'hFFFFFFFF, 4'hF, 4'hF, 1'b0,
                  8'h00, 8'h00, 8'h00, 0);
        pend = idle;
        rst = 1'b1;
        pe_bus.pe_rdy = 1'b0;
        sch2pe_vld = 1'b0;
        fe_olp_buf_rd_en = '0; addr_offset_r = '0;
        mux_col_vld = '0; mux_row_vld = '0; mux_array_vld = '0;
        row_done = 1'b0;
        drive_data(idle);
        repeat (3) @(posedge clk);
        #1;
        check("rst_ifm_zero", pe_bus.pe_ifm[255:0], 256'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_pe_vld", 256'(pe_bus.pe_vld), 256'h0);
        check("rst_align_rdy", 256'(align_rdy), 256'h1);
        check("rst_ovf", 256'(align_ovf_err), 256'h0);

        // single beat latency and plain column order
        pe_bus.pe_rdy = 1'b1;
        send(mk(4'h0, 3'd0, 32'hFFFFFFFF, 4'hF, 4'hF, 1'b0,
                8'h00, 8'h40, 8'h00, 1));
        step(1'b0, idle);
        check("lat_cycle1_vld", 256'(pe_bus.pe_vld), 256'h0);
        check("lat_cycle1_rdy", 256'(align_rdy), 256'h1);
        step(1'b0, idle);
        check("lat_cycle2_vld", 256'(pe_bus.pe_vld), 256'h1);
        check("a_row0_col5", 256'(pix(0, 5)), 256'h05);
        check("a_row2_col7", 256'(pix(2, 7)), 256'h87);
        check("a_rdy", 256'(align_rdy), 256'h1);
        drain();

        // offset 3 with olp on row1
        send(mk(4'b0010, 3'd3, 32'hFFFFFFFF, 4'hF, 4'hF, 1'b0,
                8'h00, 8'h00, 8'hA0, 2));
        step(1'b0, idle);
        step(1'b0, idle);
        check("b_row1_col0", 256'(pix(1, 0)), 256'hA3);
        check("b_row1_col4", 256'(pix(1, 4)), 256'hA7);
        check("b_row1_col5", 256'(pix(1, 5)), 256'h00);
        check("b_row1_col6", 256'(pix(1, 6)), 256'h01);
        check("b_row0_col0", 256'(pix(0, 0)), 256'h03);
        drain();

        // masks: zeroed when the option is built in, forwarded always
        b = mk(4'h0, 3'd1, 32'h0000FFFF, 4'b0101, 4'b0011, 1'b0,
               8'h10, 8'h20, 8'h00, 3);
        send(b);
        step(1'b0, idle);
        step(1'b0, idle);
        check("c_col_vld", 256'(pe_bus.pe_col_vld), 256'h0000FFFF);
        check("c_row_vld", 256'(pe_bus.pe_row_vld), 256'h5);
        check("c_row0_col3", 256'(pix(0, 3)), 256'h14);
`ifdef SCH_ALIGN_ZERO_MASK_EN
        check("c_row0_col20", 256'(pix(0, 20)), 256'h00);
        check("c_row1_col0", 256'(pix(1, 0)), 256'h00);
        check("c_wt_grp3", 256'(pe_bus.pe_wt[192 +: 64]), 256'h0);
`else
        check("c_row0_col20", 256'(pix(0, 20)), 256'h25);
        check("c_row1_col0", 256'(pix(1, 0)), 256'h31);
        check("c_wt_grp3", 256'(pe_bus.pe_wt[192 +: 64]),
              256'(b.wt[192 +: 64]));
`endif
        drain();

        // backpressure: three beats fit, the rest are refused
        pe_bus.pe_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b = mk(4'(i), 3'(i), 32'hFFFFFFFF, 4'hF, 4'hF, 1'(i == 2),
                   8'(i * 16), 8'h04, 8'hC0, 10 + i);
            step(1'b1, b);
            check($sformatf("d_rdy_beat%0d", i), 256'(align_rdy),
                  256'(i < 3));
            if (i < 3) q.push_back(model(b));
        end
        step(1'b0, idle);
        step(1'b0, idle);
        check("d_full_rdy", 256'(align_rdy), 256'h0);
        check("d_full_vld", 256'(pe_bus.pe_vld), 256'h1);
        drain();
        check("d_ovf", 256'(align_ovf_err), 256'h0);

        // streaming with no bubbles, row_last on the final beat
        pe_bus.pe_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b = mk(4'(i * 3), 3'(7 - i), 32'hFFFFFFFF, 4'hF, 4'hF,
                   1'(i == 5), 8'(i * 8), 8'h30, 8'h50, 20 + i);
            step(1'(i < 6), b);
            if (i < 6) q.push_back(model(b));
            if (i >= 2)
                check($sformatf("e_stream_vld%0d", i), 256'(pe_bus.pe_vld),
                      256'h1);
            if (i >= 2 && i < 8)
                check($sformatf("e_stream_rdy%0d", i), 256'(align_rdy),
                      256'h1);
        end
        check("e_row_last", 256'(pe_bus.pe_row_last), 256'h1);
        drain();

        // reset with two beats queued
        pe_bus.pe_rdy = 1'b0;
        send(mk(4'h0, 3'd2, 32'hFFFFFFFF, 4'hF, 4'hF, 1'b0,
                8'h11, 8'h01, 8'h00, 30));
        send(mk(4'hF, 3'd5, 32'hFFFFFFFF, 4'hF, 4'hF, 1'b1,
                8'h22, 8'h02, 8'h70, 31));
        step(1'b0, idle);
        step(1'b0, idle);
        check("f_queued_vld", 256'(pe_bus.pe_vld), 256'h1);
        rst = 1'b1;
        #1;
        check("f_rst_ifm_zero", pe_bus.pe_ifm[255:0], 256'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        #1;
        check("f_pe_vld", 256'(pe_bus.pe_vld), 256'h0);
        check("f_align_rdy", 256'(align_rdy), 256'h1);
        check("f_ovf", 256'(align_ovf_err), 256'h0);
        pe_bus.pe_rdy = 1'b1;
        repeat (3) step(1'b0, idle);
        check("f_stay_empty", 256'(pe_bus.pe_vld), 256'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
